// File: rtl/spart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spart_pkg
//  Description : Shared constants and types for the SPART word receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
package spart_pkg;

   localparam int BAUD_DIV_DEF   = 163;  // clk cycles per 16x tick (38400 baud @ 100 MHz)
   localparam int OVERSAMPLE_DEF = 16;   // ticks per serial bit
   localparam int WORD_W         = 24;
   localparam int BYTE_W         = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/spart_rx_byte.sv
`default_nettype none
// ============================================================================
//  Module      : spart_rx_byte
//  Description : Serial byte receiver: 2-flop synchronizer, free-running
//                oversample tick generator and start/data/stop bit FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
module spart_rx_byte
   import spart_pkg::*;
#(
   parameter int BAUD_DIV   = BAUD_DIV_DEF,
   parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_rx,
   output logic [BYTE_W-1:0] o_byte,
   output logic              o_byte_vld,
   output logic              o_byte_ferr
);

   localparam int c_DIV_W  = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int c_SAMP_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

   logic                r_sync1, r_sync2, r_rx_d;
   logic [c_DIV_W-1:0]  r_tick_cnt;
   rx_state_t           r_state, w_state_nxt;
   logic [c_SAMP_W-1:0] r_samp_cnt, w_samp_nxt;
   logic [2:0]          r_bit_cnt, w_bit_nxt;
   logic [BYTE_W-1:0]   r_shift, w_shift_nxt;
   logic                w_tick, w_fall, w_rx;
   logic                w_mid, w_end;

   assign w_rx   = r_sync2;
   assign w_fall = r_rx_d & ~r_sync2;
   assign w_tick = (r_tick_cnt == c_DIV_W'(BAUD_DIV - 1));
   // Mid-bit point of the start bit, and the full-bit point for data/stop.
   assign w_mid  = (r_samp_cnt == c_SAMP_W'(OVERSAMPLE / 2 - 1));
   assign w_end  = (r_samp_cnt == c_SAMP_W'(OVERSAMPLE - 1));
   assign o_byte = r_shift;

   // Synchronize the line (idle high) and keep one more stage for edge detect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_rx_d  <= 1'b1;
      end else begin
         r_sync1 <= i_rx;
         r_sync2 <= r_sync1;
         r_rx_d  <= r_sync2;
      end
   end

   // Free-running oversample tick divider.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         r_tick_cnt <= '0;
      else if (w_tick) r_tick_cnt <= '0;
      else             r_tick_cnt <= r_tick_cnt + c_DIV_W'(1);
   end

   // Bit FSM state and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_samp_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_samp_cnt <= w_samp_nxt;
         r_bit_cnt  <= w_bit_nxt;
         r_shift    <= w_shift_nxt;
      end
   end

   // Next-state logic; byte strobes fire combinationally on the stop sample.
   always_comb begin
      w_state_nxt = r_state;
      w_samp_nxt  = r_samp_cnt;
      w_bit_nxt   = r_bit_cnt;
      w_shift_nxt = r_shift;
      o_byte_vld  = 1'b0;
      o_byte_ferr = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_fall) begin
               w_state_nxt = START;
               w_samp_nxt  = '0;
            end
         end
         START: begin
            if (w_tick) begin
               if (w_mid) begin
                  w_samp_nxt  = '0;
                  w_bit_nxt   = '0;
                  // A line that has returned high was only a glitch.
                  w_state_nxt = w_rx ? IDLE : DATA;
               end else begin
                  w_samp_nxt = r_samp_cnt + c_SAMP_W'(1);
               end
            end
         end
         DATA: begin
            if (w_tick) begin
               if (w_end) begin
                  w_samp_nxt  = '0;
                  w_shift_nxt = {w_rx, r_shift[BYTE_W-1:1]};
                  w_bit_nxt   = r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) w_state_nxt = STOP;
               end else begin
                  w_samp_nxt = r_samp_cnt + c_SAMP_W'(1);
               end
            end
         end
         STOP: begin
            if (w_tick) begin
               if (w_end) begin
                  w_samp_nxt  = '0;
                  w_state_nxt = IDLE;
                  o_byte_vld  = w_rx;
                  o_byte_ferr = ~w_rx;
               end else begin
                  w_samp_nxt = r_samp_cnt + c_SAMP_W'(1);
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/spart_rx_word.sv
`default_nettype none
// ============================================================================
//  Module      : spart_rx_word
//  Description : Assembles three received bytes big-endian into a 24-bit
//                word, holds it for the processor and flags loss/framing.
//  Revision    : 1.0 - initial release
// ============================================================================
module spart_rx_word
   import spart_pkg::*;
#(
   parameter int BAUD_DIV   = BAUD_DIV_DEF,
   parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_in,
   input  logic              chip_enable,
   input  logic              r_w,
   output logic [WORD_W-1:0] data_out,
   output logic              drdy,
   output logic              ack,
   output logic              overrun,
   output logic              frame_err
);

   logic [BYTE_W-1:0]   w_byte;
   logic                w_vld, w_ferr;
   logic [1:0]          r_byte_cnt;
   logic [15:0]         r_acc;
   logic [WORD_W-1:0]   r_data;
   logic                r_drdy, r_ack, r_overrun, r_frame_err;
   logic                w_word_done, w_read, w_load, w_ovr_set;

   spart_rx_byte #(
      .BAUD_DIV   (BAUD_DIV),
      .OVERSAMPLE (OVERSAMPLE)
   ) u_rx_byte (
      .clk         (clk),
      .rst         (rst),
      .i_rx        (rx_in),
      .o_byte      (w_byte),
      .o_byte_vld  (w_vld),
      .o_byte_ferr (w_ferr)
   );

   assign w_word_done = w_vld & (r_byte_cnt == 2'd2);
   assign w_read      = chip_enable & r_w & r_drdy;
   // A simultaneous read frees the holding register for the new word.
   assign w_load      = w_word_done & (~r_drdy | w_read);
   assign w_ovr_set   = w_word_done & r_drdy & ~w_read;

   assign data_out  = r_data;
   assign drdy      = r_drdy;
   assign ack       = r_ack;
   assign overrun   = r_overrun;
   assign frame_err = r_frame_err;

   // Collect the first two bytes; a framing error restarts the word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_byte_cnt <= 2'd0;
         r_acc      <= '0;
      end else if (w_vld) begin
         case (r_byte_cnt)
            2'd0:    begin r_acc[15:8] <= w_byte; r_byte_cnt <= 2'd1; end
            2'd1:    begin r_acc[7:0]  <= w_byte; r_byte_cnt <= 2'd2; end
            default: r_byte_cnt <= 2'd0;
         endcase
      end else if (w_ferr) begin
         r_byte_cnt <= 2'd0;
      end
   end

   // Holding register, processor handshake and sticky flags (set beats clear).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data      <= '0;
         r_drdy      <= 1'b0;
         r_ack       <= 1'b0;
         r_overrun   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         if (w_load) begin
            r_data <= {r_acc, w_byte};
            r_drdy <= 1'b1;
         end else if (w_read) begin
            r_drdy <= 1'b0;
         end
         r_ack       <= w_read;
         r_overrun   <= w_ovr_set | (r_overrun & ~w_read);
         r_frame_err <= w_ferr | (r_frame_err & ~w_read);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spart_rx_word.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spart_rx_word
//  Description : Self-checking bench for spart_rx_word with a word scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spart_rx_word;

   localparam int c_BAUD = 4;
   localparam int c_OVS  = 16;
   localparam int c_BIT  = c_BAUD * c_OVS;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_in = 1'b1;
   logic        chip_enable = 1'b0;
   logic        r_w = 1'b0;
   logic [23:0] data_out;
   logic        drdy, ack, overrun, frame_err;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [23:0] sb_q[$];
   logic        prev_drdy = 1'b0;

   spart_rx_word #(
      .BAUD_DIV   (c_BAUD),
      .OVERSAMPLE (c_OVS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_in       (rx_in),
      .chip_enable (chip_enable),
      .r_w         (r_w),
      .data_out    (data_out),
      .drdy        (drdy),
      .ack         (ack),
      .overrun     (overrun),
      .frame_err   (frame_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: compare every newly presented word with the oldest expectation.
   always @(negedge clk) begin
      if (!rst && drdy && !prev_drdy) begin
         if (sb_q.size() == 0) chk("sb_unexpected_word", 32'(data_out), 32'hFFFF_FFFF);
         else                  chk("sb_word", 32'(data_out), 32'(sb_q.pop_front()));
      end
      prev_drdy = drdy;
   end

   task automatic send_bit(input logic v, input int n);
      rx_in = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      send_bit(1'b0, c_BIT);
      for (int i = 0; i < 8; i++) send_bit(b[i], c_BIT);
      send_bit(stop, c_BIT);
      send_bit(1'b1, stop ? c_BIT : 2 * c_BIT);
   endtask

   task automatic send_word(input logic [23:0] w);
      send_frame(w[23:16], 1'b1);
      send_frame(w[15:8], 1'b1);
      send_frame(w[7:0], 1'b1);
   endtask

   task automatic wait_drdy();
      int n;
      n = 0;
      while (!drdy && n < 4 * c_BIT) begin
         @(negedge clk);
         n++;
      end
      chk("drdy_timeout", 32'(drdy), 32'd1);
   endtask

   task automatic do_read(input logic [23:0] exp_data);
      chip_enable = 1'b1;
      r_w         = 1'b1;
      @(negedge clk);
      chk("read_ack", 32'(ack), 32'd1);
      chk("read_drdy", 32'(drdy), 32'd0);
      chk("read_data", 32'(data_out), 32'(exp_data));
      @(negedge clk);
      chk("read_ack_once", 32'(ack), 32'd0);
      chk("read_idle_drdy", 32'(drdy), 32'd0);
      chip_enable = 1'b0;
      r_w         = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_data", 32'(data_out), 32'd0);
      chk("rst_drdy", 32'(drdy), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_ovr", 32'(overrun), 32'd0);
      chk("rst_ferr", 32'(frame_err), 32'd0);
      rst = 1'b0;
      send_bit(1'b1, c_BIT);

      // Basic word and read
      sb_q.push_back(24'hA53C0F);
      send_word(24'hA53C0F);
      wait_drdy();
      chk("w1_ovr", 32'(overrun), 32'd0);
      chk("w1_ferr", 32'(frame_err), 32'd0);
      do_read(24'hA53C0F);

      // Short low glitch must not start a byte
      send_bit(1'b0, 4 * c_BAUD);
      send_bit(1'b1, 2 * c_BIT);
      chk("glitch_drdy", 32'(drdy), 32'd0);
      chk("glitch_ferr", 32'(frame_err), 32'd0);
      sb_q.push_back(24'h112233);
      send_word(24'h112233);
      wait_drdy();
      // Write access is ignored
      chip_enable = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("write_ack", 32'(ack), 32'd0);
      chk("write_drdy", 32'(drdy), 32'd1);
      chip_enable = 1'b0;
      do_read(24'h112233);

      // Framing error restarts the word and is sticky until read
      send_frame(8'h55, 1'b0);
      chk("ferr_set", 32'(frame_err), 32'd1);
      sb_q.push_back(24'h010203);
      send_word(24'h010203);
      wait_drdy();
      chk("ferr_sticky", 32'(frame_err), 32'd1);
      do_read(24'h010203);
      chk("ferr_clr", 32'(frame_err), 32'd0);

      // Overrun: second word lost, first kept
      sb_q.push_back(24'h000001);
      send_word(24'h000001);
      wait_drdy();
      send_word(24'h000002);
      chk("ovr_set", 32'(overrun), 32'd1);
      chk("ovr_data", 32'(data_out), 32'h000001);
      chk("ovr_drdy", 32'(drdy), 32'd1);
      do_read(24'h000001);
      chk("ovr_clr", 32'(overrun), 32'd0);

      // Reset in the middle of the second byte of a word
      send_frame(8'h77, 1'b1);
      send_bit(1'b0, c_BIT);
      for (int i = 0; i < 4; i++) send_bit(1'b1, c_BIT);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_data", 32'(data_out), 32'd0);
      chk("mid_rst_drdy", 32'(drdy), 32'd0);
      rx_in = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      send_bit(1'b1, 2 * c_BIT);
      sb_q.push_back(24'hDEADBE);
      send_word(24'hDEADBE);
      wait_drdy();
      chk("dead_ovr", 32'(overrun), 32'd0);
      do_read(24'hDEADBE);

      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/spart_rx_word.md
SPART_RX_WORD -- requirements
Module: spart_rx_word

Interface
REQ-001 The module SHALL have parameter BAUD_DIV, default 163; it is the clk cycles per 16x-oversample tick (38400 baud from 100 MHz).
REQ-002 The module SHALL have parameter OVERSAMPLE, default 16; it is the ticks per serial bit.
REQ-003 The module SHALL have port clk, input, 1 bit: the single system clock.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The module SHALL have port rx_in, input, 1 bit: the asynchronous serial line, idle high.
REQ-006 The module SHALL have port chip_enable, input, 1 bit: processor select.
REQ-007 The module SHALL have port r_w, input, 1 bit: 1 = processor read.
REQ-008 The module SHALL have port data_out, output, 24 bits: the assembled word.
REQ-009 The module SHALL have port drdy, output, 1 bit: an unread word is held.
REQ-010 The module SHALL have port ack, output, 1 bit: one-cycle read acknowledge.
REQ-011 The module SHALL have port overrun, output, 1 bit: a sticky flag set when a word is lost.
REQ-012 The module SHALL have port frame_err, output, 1 bit: a sticky flag set on a bad stop bit.

Function
REQ-013 rx_in SHALL pass through a 2-flop synchronizer before any use.
REQ-014 The tick counter SHALL count 0..BAUD_DIV-1 and emit a one-cycle tick at wrap; it SHALL free-run.
REQ-015 The bit FSM SHALL have the states IDLE, START, DATA, STOP.
REQ-016 In IDLE, a synchronized 1->0 transition SHALL enter START and clear the tick-in-bit count.
REQ-017 In START, rx_in SHALL be resampled at tick 8; if it is 0, the FSM SHALL enter DATA; if it is 1 (false start), the FSM SHALL return to IDLE.
REQ-018 In DATA, the FSM SHALL sample 8 bits, one every 16 ticks, LSB first, into a shift register, then enter STOP.
REQ-019 In STOP, the FSM SHALL sample after 16 ticks. A 1 SHALL deliver a good byte. A 0 SHALL set frame_err, discard the byte and reset the byte count to 0. Either way, the FSM SHALL return to IDLE.
REQ-020 The byte count (0..2) SHALL assemble good bytes big-endian: the first byte goes to [23:16], the second to [15:8] and the third to [7:0].
REQ-021 On the third good byte, the cycle after the stop sample, data_out SHALL load the word, drdy SHALL become 1, and the byte count SHALL wrap to 0.
REQ-022 A read SHALL be chip_enable & r_w & drdy sampled at a clk edge; the next cycle, ack=1 for exactly one cycle, drdy=0, and overrun and frame_err SHALL be cleared.
REQ-023 chip_enable & r_w while drdy=0 SHALL produce no ack and no state change.
REQ-024 chip_enable with r_w=0 SHALL be ignored.
REQ-025 data_out SHALL remain stable until the next word load, including after a read.
REQ-026 If a word completes while drdy=1 and no read is accepted in the same cycle, the new word SHALL be discarded, data_out SHALL be kept and overrun SHALL be set.
REQ-027 If a read and a word completion occur in the same cycle, the new word SHALL load, drdy SHALL stay 1, ack SHALL pulse and overrun SHALL stay 0.
REQ-028 A sticky flag set in the same cycle as a read SHALL remain set, because set wins over clear.

Reset
REQ-029 Asserting rst SHALL immediately force: data_out=0, drdy=0, ack=0, overrun=0, frame_err=0, FSM=IDLE, byte count=0, tick counter=0, synchronizer flops=1.
REQ-030 Reset mid-frame SHALL abandon the partial byte and partial word; after release, the FSM SHALL wait for a fresh falling edge.

Structure
REQ-031 Package spart_pkg SHALL hold: BAUD_DIV and OVERSAMPLE defaults, the rx state enum {IDLE, START, DATA, STOP}, and the WORD_W=24 and BYTE_W=8 constants.
REQ-032 Sub-module spart_rx_byte SHALL implement the synchronizer, tick counter and bit FSM, outputting byte[7:0], byte_vld (one cycle) and byte_ferr (one cycle).
REQ-033 The top level SHALL implement word assembly, the holding register and the processor handshake.

Verification
REQ-034 Frames 0xA5, 0x3C, 0x0F with good stops -> data_out=0xA53C0F and drdy=1 one cycle after the third stop sample; overrun=0 and frame_err=0.
REQ-035 Then chip_enable=1, r_w=1 for one cycle -> ack=1 for exactly one cycle, drdy=0, and data_out still 0xA53C0F.
REQ-036 A 4-tick low glitch on rx_in -> FSM returns to IDLE, no byte is delivered, and the next frames 0x11, 0x22, 0x33 -> 0x112233.
REQ-037 Frame 0x55 with stop=0, then 0x01, 0x02, 0x03 -> frame_err=1 and data_out=0x010203.
REQ-038 Two full words (0x000001, then 0x000002) with no read -> data_out=0x000001, overrun=1; after a read, overrun=0.
REQ-039 rst pulsed after 4 data bits of the second byte, then three fresh frames 0xDE, 0xAD, 0xBE -> data_out=0xDEADBE, and no residue from the aborted word.
